// File: rtl/sc_lifeloss_ctrl.sv
// Life-loss controller: detects a sustained frog/obstacle overlap, strobes one life
// decrement, then runs a timed invulnerability window or latches game over.
module sc_lifeloss_ctrl #(
    parameter int          DATAWIDTH_2   = 2,
    parameter int          DATAWIDTH_8   = 8,
    parameter logic [15:0] RESPAWN_TICKS = 16'd50000
) (
    input  logic                   SC_LIFELOSS_CLOCK_50,
    input  logic                   SC_LIFELOSS_RESET_InHigh,
    input  logic [DATAWIDTH_8-1:0] SC_LIFELOSS_FROG_InBUS,
    input  logic [DATAWIDTH_8-1:0] SC_LIFELOSS_CARS_InBUS,
    input  logic [DATAWIDTH_2-1:0] SC_LIFELOSS_LIVES_InBUS,
    input  logic                   SC_LIFELOSS_ENABLE_InHigh,
    output logic                   SC_LIFELOSS_CUENTA_OutLow,
    output logic                   SC_LIFELOSS_RESPAWN_OutHigh,
    output logic                   SC_LIFELOSS_INVULN_OutHigh,
    output logic                   SC_LIFELOSS_GAMEOVER_OutHigh,
    output logic [1:0]             SC_LIFELOSS_STATE_OutBUS
);

    typedef enum logic [1:0] {
        ST_PLAY     = 2'b00,
        ST_HIT      = 2'b01,
        ST_RESPAWN  = 2'b10,
        ST_GAMEOVER = 2'b11
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        filter_reg;
    logic        filter_next;
    logic [15:0] timer_reg;
    logic [15:0] timer_next;
    logic        respawn_reg;
    logic        respawn_next;
    logic        collision;
    logic        lives_zero;
    logic        lives_one;

    assign collision  = |(SC_LIFELOSS_FROG_InBUS & SC_LIFELOSS_CARS_InBUS);
    assign lives_zero = (SC_LIFELOSS_LIVES_InBUS == '0);
    assign lives_one  = (SC_LIFELOSS_LIVES_InBUS == DATAWIDTH_2'(1));

    always_ff @(posedge SC_LIFELOSS_CLOCK_50) begin
        if (SC_LIFELOSS_RESET_InHigh) begin
            state_reg   <= ST_PLAY;
            filter_reg  <= 1'b0;
            timer_reg   <= 16'd0;
            respawn_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            filter_reg  <= filter_next;
            timer_reg   <= timer_next;
            respawn_reg <= respawn_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        filter_next  = 1'b0;
        timer_next   = timer_reg;
        respawn_next = 1'b0;
        case (state_reg)
            ST_PLAY: begin
                // A hit needs the overlap on two consecutive enabled edges; a paused game holds.
                if (SC_LIFELOSS_ENABLE_InHigh) begin
                    filter_next = collision;
                    if (lives_zero) begin
                        state_next = ST_GAMEOVER;
                    end else if (collision && filter_reg) begin
                        state_next = ST_HIT;
                    end
                end
            end
            ST_HIT: begin
                if (lives_one) begin
                    state_next = ST_GAMEOVER;
                end else begin
                    state_next   = ST_RESPAWN;
                    timer_next   = RESPAWN_TICKS - 16'd1;
                    respawn_next = 1'b1;
                end
            end
            ST_RESPAWN: begin
                if (SC_LIFELOSS_ENABLE_InHigh) begin
                    if (timer_reg == 16'd0) begin
                        state_next = ST_PLAY;
                    end else begin
                        timer_next = timer_reg - 16'd1;
                    end
                end
            end
            default: begin
                state_next = ST_GAMEOVER;
            end
        endcase
    end

    // Every output is either a register or a pure decode of the state register.
    assign SC_LIFELOSS_CUENTA_OutLow    = (state_reg != ST_HIT);
    assign SC_LIFELOSS_RESPAWN_OutHigh  = respawn_reg;
    assign SC_LIFELOSS_INVULN_OutHigh   = (state_reg == ST_RESPAWN);
    assign SC_LIFELOSS_GAMEOVER_OutHigh = (state_reg == ST_GAMEOVER);
    assign SC_LIFELOSS_STATE_OutBUS     = state_reg;

endmodule

// File: tb/tb_sc_lifeloss_ctrl.sv
// Bench for sc_lifeloss_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against an event-level reference model.
module tb_sc_lifeloss_ctrl;

    localparam int TICKS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] frog;
    logic [7:0] cars;
    logic [1:0] lives;
    logic       en;
    logic       cuenta;
    logic       respawn;
    logic       invuln;
    logic       gameover;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 play, 1 hit, 2 respawn, 3 game over.
    int m_phase = 0;
    int m_left  = 0;
    bit m_prev  = 1'b0;
    bit m_pulse = 1'b0;

    always #5 clk = ~clk;

    sc_lifeloss_ctrl #(
        .DATAWIDTH_2  (2),
        .DATAWIDTH_8  (8),
        .RESPAWN_TICKS(16'(TICKS))
    ) dut (
        .SC_LIFELOSS_CLOCK_50        (clk),
        .SC_LIFELOSS_RESET_InHigh    (rst),
        .SC_LIFELOSS_FROG_InBUS      (frog),
        .SC_LIFELOSS_CARS_InBUS      (cars),
        .SC_LIFELOSS_LIVES_InBUS     (lives),
        .SC_LIFELOSS_ENABLE_InHigh   (en),
        .SC_LIFELOSS_CUENTA_OutLow   (cuenta),
        .SC_LIFELOSS_RESPAWN_OutHigh (respawn),
        .SC_LIFELOSS_INVULN_OutHigh  (invuln),
        .SC_LIFELOSS_GAMEOVER_OutHigh(gameover),
        .SC_LIFELOSS_STATE_OutBUS    (state)
    );

    // Packed as {state, cuenta, respawn, invuln, gameover}.
    function automatic logic [5:0] dut_out();
        return {state, cuenta, respawn, invuln, gameover};
    endfunction

    function automatic logic [5:0] model_out();
        logic [1:0] ph;
        ph = 2'(m_phase);
        return {ph, (m_phase != 1), m_pulse, (m_phase == 2), (m_phase == 3)};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit ov;
        ov = |(frog & cars);
        m_pulse = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_prev  = 1'b0;
            m_left  = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (en) begin
                        if (lives == 2'd0) m_phase = 3;
                        else if (ov && m_prev) m_phase = 1;
                        m_prev = ov;
                    end else begin
                        m_prev = 1'b0;
                    end
                end
                1: begin
                    m_prev = 1'b0;
                    if (lives == 2'd1) m_phase = 3;
                    else begin
                        m_phase = 2;
                        m_left  = TICKS;
                        m_pulse = 1'b1;
                    end
                end
                2: begin
                    m_prev = 1'b0;
                    if (en) begin
                        m_left--;
                        if (m_left == 0) m_phase = 0;
                    end
                end
                default: m_prev = 1'b0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model", dut_out(), model_out());
    endtask

    task automatic drive(input logic r, input logic [7:0] f, input logic [7:0] c,
                         input logic [1:0] l, input logic e);
        rst   = r;
        frog  = f;
        cars  = c;
        lives = l;
        en    = e;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] frog;
        logic [7:0] cars;
        logic [1:0] lives;
        logic       en;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] O_PLAY = 6'b00_1000;
    localparam logic [5:0] O_HIT  = 6'b01_0000;
    localparam logic [5:0] O_RSP1 = 6'b10_1110;
    localparam logic [5:0] O_RSP  = 6'b10_1010;
    localparam logic [5:0] O_OVER = 6'b11_1001;

    vec_t tbl[16];

    initial begin
        int cnt;
        int lows;
        drive(1'b1, 8'h00, 8'h00, 2'd3, 1'b1);

        tbl[0]  = '{1'b1, 8'h10, 8'h10, 2'd3, 1'b1, O_PLAY};
        tbl[1]  = '{1'b0, 8'h10, 8'h10, 2'd3, 1'b1, O_PLAY};
        tbl[2]  = '{1'b0, 8'h10, 8'h00, 2'd3, 1'b1, O_PLAY};
        tbl[3]  = '{1'b0, 8'h01, 8'h80, 2'd3, 1'b1, O_PLAY};
        tbl[4]  = '{1'b0, 8'h10, 8'h10, 2'd3, 1'b1, O_PLAY};
        tbl[5]  = '{1'b0, 8'h10, 8'h10, 2'd3, 1'b1, O_HIT};
        tbl[6]  = '{1'b0, 8'h10, 8'h10, 2'd3, 1'b1, O_RSP1};
        tbl[7]  = '{1'b0, 8'h10, 8'h10, 2'd2, 1'b1, O_RSP};
        tbl[8]  = '{1'b0, 8'h10, 8'h10, 2'd2, 1'b1, O_RSP};
        tbl[9]  = '{1'b0, 8'h10, 8'h10, 2'd2, 1'b1, O_RSP};
        tbl[10] = '{1'b0, 8'h10, 8'h10, 2'd2, 1'b1, O_PLAY};
        tbl[11] = '{1'b0, 8'h00, 8'h10, 2'd2, 1'b1, O_PLAY};
        tbl[12] = '{1'b0, 8'hff, 8'h01, 2'd2, 1'b0, O_PLAY};
        tbl[13] = '{1'b0, 8'h00, 8'h00, 2'd0, 1'b1, O_OVER};
        tbl[14] = '{1'b0, 8'hff, 8'hff, 2'd3, 1'b1, O_OVER};
        tbl[15] = '{1'b1, 8'hff, 8'hff, 2'd3, 1'b1, O_PLAY};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].frog, tbl[i].cars, tbl[i].lives, tbl[i].en);
            tick();
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // Pause for three cycles in the middle of the invulnerability window.
        drive(1'b1, 8'h00, 8'h00, 2'd3, 1'b1);
        tick();
        drive(1'b0, 8'h04, 8'h04, 2'd3, 1'b1);
        tick();
        tick();
        check("pause_hit", dut_out(), O_HIT);
        drive(1'b0, 8'h00, 8'h00, 2'd3, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            en = !(i >= 2 && i < 5);
            tick();
            if (invuln) cnt++;
        end
        check("pause_invuln_len", 6'(cnt), 6'd7);
        check("pause_end", dut_out(), O_PLAY);

        // Last life: one strobe, then absorbing game over under constant overlap.
        drive(1'b1, 8'h00, 8'h00, 2'd1, 1'b1);
        tick();
        drive(1'b0, 8'h20, 8'h30, 2'd1, 1'b1);
        lows = 0;
        for (int i = 0; i < 104; i++) begin
            tick();
            if (!cuenta) lows++;
        end
        check("last_life_strobes", 6'(lows), 6'd1);
        check("last_life_over", dut_out(), O_OVER);
        rst = 1'b1;
        tick();
        check("over_reset", dut_out(), O_PLAY);

        // Lives at zero while playing: immediate game over, no strobe.
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
        lows = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!cuenta) lows++;
        end
        check("zero_lives_over", dut_out(), O_OVER);
        check("zero_lives_strobes", 6'(lows), 6'd0);

        // Reset landing in the second respawn cycle.
        drive(1'b1, 8'h00, 8'h00, 2'd3, 1'b1);
        tick();
        drive(1'b0, 8'h80, 8'h80, 2'd3, 1'b1);
        tick();
        tick();
        tick();
        check("mid_rsp_first", dut_out(), O_RSP1);
        tick();
        check("mid_rsp_second", dut_out(), O_RSP);
        rst = 1'b1;
        tick();
        check("mid_rsp_reset", dut_out(), O_PLAY);

        // Randomized run; the model comparison inside tick does the checking.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            frog  = 8'(1 << $urandom_range(0, 7));
            cars  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : frog;
            if ($urandom_range(0, 3) == 0) cars = 8'h00;
            lives = ($urandom_range(0, 39) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            en    = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sc_lifeloss_ctrl.md
SC_LIFELOSS_CTRL -- requirements
Module: sc_lifeloss_ctrl

Interface
REQ-001 The block SHALL have the parameter DATAWIDTH_2, default 2: width of the lives bus.
REQ-002 The block SHALL have the parameter DATAWIDTH_8, default 8: width of the row bitmaps.
REQ-003 The block SHALL have the parameter RESPAWN_TICKS, default 16'd50000: number of cycles of invulnerability after a hit, legal range 1..65535.
REQ-004 The block SHALL have the port SC_LIFELOSS_CLOCK_50  input  1: the single clock; one clock only, all logic on its rising edge.
REQ-005 The block SHALL have the port SC_LIFELOSS_RESET_InHigh  input  1: the reset, synchronous and active-high.
REQ-006 The block SHALL have the port SC_LIFELOSS_FROG_InBUS  input  DATAWIDTH_8: frog bitmap on the frog's current row.
REQ-007 The block SHALL have the port SC_LIFELOSS_CARS_InBUS  input  DATAWIDTH_8: obstacle bitmap on the same row.
REQ-008 The block SHALL have the port SC_LIFELOSS_LIVES_InBUS  input  DATAWIDTH_2: current life count, fed back from the life counter.
REQ-009 The block SHALL have the port SC_LIFELOSS_ENABLE_InHigh  input  1: game running; low means paused.
REQ-010 The block SHALL have the port SC_LIFELOSS_CUENTA_OutLow  output  1: active-low one-cycle decrement strobe to the life counter.
REQ-011 The block SHALL have the port SC_LIFELOSS_RESPAWN_OutHigh  output  1: one-cycle pulse that returns the frog to its start position.
REQ-012 The block SHALL have the port SC_LIFELOSS_INVULN_OutHigh  output  1: high while the respawn window is active.
REQ-013 The block SHALL have the port SC_LIFELOSS_GAMEOVER_OutHigh  output  1: level, high in GAMEOVER.
REQ-014 The block SHALL have the port SC_LIFELOSS_STATE_OutBUS  output  2: state code, for debug.

Function
REQ-015 The collision term SHALL be the OR-reduction of FROG_InBUS AND CARS_InBUS; it SHALL be combinational and unregistered.
REQ-016 The block SHALL have a 1-bit filter register that captures the collision term on every clock edge while the state is PLAY and ENABLE=1; the filter SHALL be cleared in every other case.
REQ-017 The FSM SHALL use these state encodings: PLAY=2'b00, HIT=2'b01, RESPAWN=2'b10, GAMEOVER=2'b11; STATE_OutBUS SHALL be the state register.
REQ-018 In PLAY, if LIVES_InBUS==0 the FSM SHALL go to GAMEOVER with no decrement strobe; this check SHALL take priority over collision.
REQ-019 In PLAY with ENABLE=1, if the collision term and the filter are both 1, the FSM SHALL go to HIT (two consecutive colliding edges are required); otherwise it SHALL stay in PLAY.
REQ-020 In PLAY with ENABLE=0, the FSM SHALL hold its state.
REQ-021 HIT SHALL last exactly one cycle regardless of ENABLE, and CUENTA_OutLow SHALL be 0 during that cycle only.
REQ-022 On leaving HIT, if LIVES_InBUS==1 (the value before the decrement) the FSM SHALL go to GAMEOVER; otherwise it SHALL go to RESPAWN and load the timer with RESPAWN_TICKS-1.
REQ-023 In RESPAWN, RESPAWN_OutHigh SHALL be 1 in the first RESPAWN cycle only.
REQ-024 In RESPAWN, INVULN_OutHigh SHALL be 1 in every RESPAWN cycle.
REQ-025 In RESPAWN, the collision term SHALL be ignored.
REQ-026 In RESPAWN, the timer SHALL decrement by 1 per cycle while ENABLE=1 and freeze while ENABLE=0.
REQ-027 In RESPAWN, when the timer==0 and ENABLE=1 the FSM SHALL go to PLAY; RESPAWN therefore lasts exactly RESPAWN_TICKS enabled cycles.
REQ-028 The timer SHALL be 16 bits wide, unsigned, and SHALL NOT underflow or wrap.
REQ-029 GAMEOVER SHALL be absorbing: the FSM SHALL leave it only through reset.
REQ-030 In GAMEOVER, GAMEOVER_OutHigh SHALL be 1, CUENTA_OutLow SHALL be 1, and collisions SHALL be ignored.
REQ-031 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from any input to any output.
REQ-032 The block SHALL emit at most one decrement strobe per hit, so the life counter never sees back-to-back low cycles.

Reset
REQ-033 While RESET_InHigh=1 at a clock edge, the next state SHALL be: state=PLAY, filter=0, timer=0, CUENTA_OutLow=1, RESPAWN_OutHigh=0, INVULN_OutHigh=0, GAMEOVER_OutHigh=0, STATE_OutBUS=2'b00.
REQ-034 Reset SHALL override every state, including mid-HIT and mid-RESPAWN, and a strobe in flight SHALL be dropped.

Verification (RESPAWN_TICKS=4, LIVES held by the bench unless stated)
REQ-035 Reset, LIVES=3, a single-cycle overlap FROG=8'h10/CARS=8'h10 -> CUENTA stays 1 and the state stays 2'b00.
REQ-036 LIVES=3, overlap held on edges t and t+1 -> STATE=2'b01 and CUENTA=0 for exactly the one cycle after t+1; then RESPAWN=1 for one cycle and INVULN=1 for 4 cycles with overlap still held, no second strobe, then STATE=2'b00.
REQ-037 RESPAWN with ENABLE dropped for 3 cycles mid-window -> INVULN stays high for 4+3=7 cycles total.
REQ-038 LIVES=1, two-cycle overlap -> one CUENTA low cycle, then STATE=2'b11 and GAMEOVER=1, held for 100 cycles under continuous overlap; reset then gives STATE=2'b00 and GAMEOVER=0.
REQ-039 LIVES=0 while in PLAY -> GAMEOVER=1 on the next edge, with CUENTA never low.
REQ-040 Reset asserted in the second RESPAWN cycle -> on the next edge STATE=2'b00 and INVULN=0, with all outputs at their reset values.
